// File: rtl/axon_fanout.sv
// Axon fan-out stage: expands each accepted spike over a KxK kernel into
// synaptic events for the synapse/dendrite stage, with a one-cycle GAP after
// each spike so sd's read-modify-write never sees back-to-back spikes.
// Optional feature macro: AXON_PERF_CNT_EN adds spike/event performance counters.
module axon_fanout #(
    parameter int unsigned SW      = 24,
    parameter int unsigned NNW     = 12,
    parameter int unsigned WD      = 6,
    parameter int unsigned LAN_num = 2
) (
    input  logic               clk_AXON,
    input  logic               rst,
    input  logic [SW-1:0]      spk_in_data,
    input  logic               spk_in_vld,
    output logic               spk_in_rdy,
    input  logic               config_axon_en,
    input  logic [3:0]         config_axon_ksize,
    input  logic [7:0]         config_axon_out_w,
    input  logic [7:0]         config_axon_out_h,
    output logic [NNW-1:0]     axon_sd_vm_addr,
    output logic [WD-1:0]      axon_sd_wgt_addr,
    output logic [LAN_num-1:0] axon_sd_lans,
    output logic               axon_sd_vld,
    output logic               axon_busy
`ifdef AXON_PERF_CNT_EN
    ,
    input  logic               perf_clr,
    output logic [31:0]        perf_spk_cnt,
    output logic [31:0]        perf_evt_cnt
`endif
);

    typedef enum logic [1:0] {StIdle, StExpand, StGap} state_e;

    state_e             state_q, state_d;
    logic [7:0]         x_q, y_q, out_w_q, out_h_q;
    logic [LAN_num-1:0] lans_q;
    logic [3:0]         k_q, k_clamp;
    logic [2:0]         kx_q, ky_q;
    logic               accept, last_kx, last_ky, in_bounds;
    logic [8:0]         tx, ty;
    logic [16:0]        addr_full;
    logic               unused_z;

    // Bits of z above the lane field carry no meaning for this stage.
    assign unused_z = ^spk_in_data[7:LAN_num];

    assign spk_in_rdy = config_axon_en && (state_q == StIdle) && !rst;
    assign accept     = spk_in_vld && spk_in_rdy;
    assign axon_busy  = (state_q != StIdle) || axon_sd_vld;

    // Clamp the requested kernel size into 1..8.
    always_comb begin
        k_clamp = config_axon_ksize;
        if (config_axon_ksize == 4'd0) begin
            k_clamp = 4'd1;
        end else if (config_axon_ksize > 4'd8) begin
            k_clamp = 4'd8;
        end
    end

    assign last_kx = ({1'b0, kx_q} == (k_q - 4'd1));
    assign last_ky = ({1'b0, ky_q} == (k_q - 4'd1));

    // 9-bit two's complement: bit 8 set means the target fell below zero.
    assign tx = {1'b0, x_q} - {6'b0, kx_q};
    assign ty = {1'b0, y_q} - {6'b0, ky_q};
    assign in_bounds = !tx[8] && (tx[7:0] < out_w_q) && !ty[8] && (ty[7:0] < out_h_q);
    assign addr_full = ({9'b0, ty[7:0]} * {9'b0, out_w_q}) + {9'b0, tx[7:0]};

    // Next-state: IDLE -> EXPAND for K*K cycles -> one GAP cycle -> IDLE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (accept) state_d = StExpand;
            StExpand: if (last_kx && last_ky) state_d = StGap;
            StGap:    state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // State register.
    always_ff @(posedge clk_AXON) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Latch the spike and its config on accept; step the kernel, kx fastest.
    always_ff @(posedge clk_AXON) begin
        if (rst) begin
            x_q     <= '0;
            y_q     <= '0;
            lans_q  <= '0;
            k_q     <= 4'd1;
            out_w_q <= '0;
            out_h_q <= '0;
            kx_q    <= '0;
            ky_q    <= '0;
        end else if (accept) begin
            x_q     <= spk_in_data[23:16];
            y_q     <= spk_in_data[15:8];
            lans_q  <= spk_in_data[LAN_num-1:0];
            k_q     <= k_clamp;
            out_w_q <= config_axon_out_w;
            out_h_q <= config_axon_out_h;
            kx_q    <= '0;
            ky_q    <= '0;
        end else if (state_q == StExpand) begin
            if (last_kx) begin
                kx_q <= '0;
                ky_q <= ky_q + 3'd1;
            end else begin
                kx_q <= kx_q + 3'd1;
            end
        end
    end

    // Registered event outputs; addresses hold their last value when idle.
    always_ff @(posedge clk_AXON) begin
        if (rst) begin
            axon_sd_vld      <= 1'b0;
            axon_sd_vm_addr  <= '0;
            axon_sd_wgt_addr <= '0;
            axon_sd_lans     <= '0;
        end else begin
            axon_sd_vld <= (state_q == StExpand) && in_bounds;
            if ((state_q == StExpand) && in_bounds) begin
                axon_sd_vm_addr  <= addr_full[NNW-1:0];
                axon_sd_wgt_addr <= {ky_q, kx_q};
                axon_sd_lans     <= lans_q;
            end
        end
    end

`ifdef AXON_PERF_CNT_EN
    // Performance counters; clear takes priority over a same-cycle increment.
    always_ff @(posedge clk_AXON) begin
        if (rst || perf_clr) begin
            perf_spk_cnt <= '0;
            perf_evt_cnt <= '0;
        end else begin
            if (accept) perf_spk_cnt <= perf_spk_cnt + 32'd1;
            if (axon_sd_vld) perf_evt_cnt <= perf_evt_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_axon_fanout.sv
// Scoreboard bench for axon_fanout: expected events are queued with the
// stimulus, a negedge monitor pops and compares every valid event.
module tb_axon_fanout;

    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] spk_in_data;
    logic        spk_in_vld;
    logic        spk_in_rdy;
    logic        config_axon_en;
    logic [3:0]  config_axon_ksize;
    logic [7:0]  config_axon_out_w;
    logic [7:0]  config_axon_out_h;
    logic [11:0] axon_sd_vm_addr;
    logic [5:0]  axon_sd_wgt_addr;
    logic [1:0]  axon_sd_lans;
    logic        axon_sd_vld;
    logic        axon_busy;
    logic        perf_clr;
    logic [31:0] perf_spk_cnt;
    logic [31:0] perf_evt_cnt;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [31:0] id;
        logic [11:0] vm;
        logic [5:0]  wgt;
        logic [1:0]  lans;
    } evt_t;

    evt_t exp_q[$];
    int   cur_id  = 0;
    int   last_id = -1;
    int   idle_run = 100;

    int t1_vm  [9] = '{85, 84, 83, 69, 68, 67, 53, 52, 51};
    int t1_wgt [9] = '{0, 1, 2, 8, 9, 10, 16, 17, 18};

    always #5 clk = ~clk;

    axon_fanout dut (
        .clk_AXON          (clk),
        .rst               (rst),
        .spk_in_data       (spk_in_data),
        .spk_in_vld        (spk_in_vld),
        .spk_in_rdy        (spk_in_rdy),
        .config_axon_en    (config_axon_en),
        .config_axon_ksize (config_axon_ksize),
        .config_axon_out_w (config_axon_out_w),
        .config_axon_out_h (config_axon_out_h),
        .axon_sd_vm_addr   (axon_sd_vm_addr),
        .axon_sd_wgt_addr  (axon_sd_wgt_addr),
        .axon_sd_lans      (axon_sd_lans),
        .axon_sd_vld       (axon_sd_vld),
        .axon_busy         (axon_busy)
`ifdef AXON_PERF_CNT_EN
        ,
        .perf_clr          (perf_clr),
        .perf_spk_cnt      (perf_spk_cnt),
        .perf_evt_cnt      (perf_evt_cnt)
`endif
    );

`ifndef AXON_PERF_CNT_EN
    assign perf_spk_cnt = '0;
    assign perf_evt_cnt = '0;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input int vm, input int wgt, input int lans);
        evt_t e;
        e.id   = cur_id;
        e.vm   = vm[11:0];
        e.wgt  = wgt[5:0];
        e.lans = lans[1:0];
        exp_q.push_back(e);
    endtask

    task automatic set_cfg(input int k, input int w, input int h);
        config_axon_ksize = k[3:0];
        config_axon_out_w = w[7:0];
        config_axon_out_h = h[7:0];
    endtask

    // Returns one cycle after the handshake edge (first EXPAND cycle).
    task automatic send(input int x, input int y, input int z, input bit keep);
        bit got = 0;
        @(posedge clk); #1;
        spk_in_data = {x[7:0], y[7:0], z[7:0]};
        spk_in_vld  = 1'b1;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (spk_in_rdy === 1'b1) got = 1;
        end
        if (!got) begin
            failures++;
            $display("FAIL send_timeout: rdy never seen for spike (%0d,%0d)", x, y);
        end
        @(posedge clk); #1;
        if (!keep) spk_in_vld = 1'b0;
    endtask

    // Counts busy cycles from the current cycle until busy drops.
    task automatic wait_done(input int exp_cycles, input string name);
        int n = 0;
        @(negedge clk);
        while (axon_busy === 1'b1 && n < 300) begin
            n++;
            @(negedge clk);
        end
        chk({name, "_busy_cycles"}, n, exp_cycles);
        chk({name, "_events_left"}, exp_q.size(), 0);
    endtask

    // Monitor: scoreboard compare, inter-spike gap, and no ready while busy.
    always @(negedge clk) begin
        evt_t e;
        if (axon_busy === 1'b1) begin
            checks++;
            if (spk_in_rdy !== 1'b0) begin
                failures++;
                $display("FAIL rdy_while_busy: rdy=%0b expected 0", spk_in_rdy);
            end
        end
        if (axon_sd_vld === 1'b1) begin
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_event: vm=%0d wgt=%0d lans=%0d expected none",
                         axon_sd_vm_addr, axon_sd_wgt_addr, axon_sd_lans);
            end else begin
                e = exp_q.pop_front();
                checks++;
                if (axon_sd_vm_addr !== e.vm || axon_sd_wgt_addr !== e.wgt ||
                    axon_sd_lans !== e.lans) begin
                    failures++;
                    $display("FAIL event_spk%0d: got vm=%0d wgt=%0d lans=%0d expected vm=%0d wgt=%0d lans=%0d",
                             e.id, axon_sd_vm_addr, axon_sd_wgt_addr, axon_sd_lans,
                             e.vm, e.wgt, e.lans);
                end
                if (last_id >= 0 && int'(e.id) != last_id) begin
                    checks++;
                    if (idle_run < 2) begin
                        failures++;
                        $display("FAIL spike_gap: got %0d idle cycles expected >=2", idle_run);
                    end
                end
                last_id = int'(e.id);
            end
            idle_run = 0;
        end else begin
            idle_run++;
        end
    end

    initial begin
        rst            = 1'b1;
        spk_in_data    = '0;
        spk_in_vld     = 1'b0;
        config_axon_en = 1'b1;
        perf_clr       = 1'b0;
        set_cfg(3, 16, 16);

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_vld", axon_sd_vld, 0);
        chk("rst_vm", axon_sd_vm_addr, 0);
        chk("rst_wgt", axon_sd_wgt_addr, 0);
        chk("rst_lans", axon_sd_lans, 0);
        chk("rst_busy", axon_busy, 0);
        chk("rst_rdy", spk_in_rdy, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("idle_rdy", spk_in_rdy, 1);

        // T1: 3x3 fan-out fully inside a 16x16 map
        cur_id = 1;
        for (int i = 0; i < 9; i++) push(t1_vm[i], t1_wgt[i], 2);
        send(5, 5, 2, 0);
        wait_done(10, "t1");

        // T2: low corner, only kx=ky=0 lands in bounds
        cur_id = 2;
        push(0, 0, 1);
        send(0, 0, 1, 0);
        wait_done(10, "t2");

`ifdef AXON_PERF_CNT_EN
        // T6: counters after T1+T2, then clear
        @(negedge clk);
        chk("perf_spk", perf_spk_cnt, 2);
        chk("perf_evt", perf_evt_cnt, 10);
        @(posedge clk); #1;
        perf_clr = 1'b1;
        @(posedge clk); #1;
        perf_clr = 1'b0;
        @(negedge clk);
        chk("perf_spk_clr", perf_spk_cnt, 0);
        chk("perf_evt_clr", perf_evt_cnt, 0);
`endif

        // T3: high corner
        set_cfg(2, 16, 16);
        cur_id = 3;
        push(255, 0, 0); push(254, 1, 0); push(239, 8, 0); push(238, 9, 0);
        send(15, 15, 0, 0);
        wait_done(5, "t3a");
        set_cfg(4, 16, 16);
        cur_id = 4;
        push(255, 27, 3);
        send(18, 18, 3, 0);
        wait_done(17, "t3b");

        // Non-square map: width 10, height 4
        set_cfg(2, 10, 4);
        cur_id = 5;
        push(33, 8, 3); push(32, 9, 3);
        send(3, 4, 3, 0);
        wait_done(5, "rect");

        // Kernel clamping: 0 -> 1, 15 -> 8
        set_cfg(0, 16, 16);
        cur_id = 6;
        push(50, 0, 0);
        send(2, 3, 0, 0);
        wait_done(2, "k0");
        set_cfg(15, 16, 16);
        cur_id = 7;
        push(0, 0, 1);
        send(0, 0, 1, 0);
        wait_done(65, "k15");

        // T4: back-to-back spikes with valid held high
        set_cfg(1, 16, 16);
        cur_id = 8;
        push(68, 0, 1);
        cur_id = 9;
        push(69, 0, 2);
        send(4, 4, 1, 1);
        send(5, 4, 2, 0);
        wait_done(2, "t4");

        // T5a: disabled block accepts nothing
        config_axon_en = 1'b0;
        @(posedge clk); #1;
        spk_in_data = {8'd5, 8'd5, 8'd1};
        spk_in_vld  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("dis_rdy", spk_in_rdy, 0);
        end
        @(posedge clk); #1;
        spk_in_vld = 1'b0;
        repeat (3) @(negedge clk);
        chk("dis_busy", axon_busy, 0);
        config_axon_en = 1'b1;

        // T5b: en and config change mid-EXPAND do not disturb the spike
        set_cfg(3, 16, 16);
        cur_id = 10;
        for (int i = 0; i < 9; i++) push(t1_vm[i], t1_wgt[i], 2);
        send(5, 5, 2, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        config_axon_en = 1'b0;
        set_cfg(1, 8, 8);
        wait_done(8, "en_drop");
        chk("en_drop_rdy", spk_in_rdy, 0);
        config_axon_en = 1'b1;
        set_cfg(3, 16, 16);

        // T5c: reset mid-EXPAND drops the remaining candidates
        cur_id = 11;
        push(85, 0, 2); push(84, 1, 2); push(83, 2, 2);
        send(5, 5, 2, 0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("mid_rst_vld", axon_sd_vld, 0);
        chk("mid_rst_vm", axon_sd_vm_addr, 0);
        chk("mid_rst_wgt", axon_sd_wgt_addr, 0);
        chk("mid_rst_busy", axon_busy, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_rdy", spk_in_rdy, 1);
        repeat (12) @(negedge clk);
        chk("post_rst_events_left", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
